// File: rtl/lfsr_pkg.sv
// Shared defaults and a reference step function for the 32-bit Galois LFSR.
package lfsr_pkg;

   localparam int unsigned     LFSR_WIDTH_DEF = 32;
   localparam logic [31:0]     LFSR_TAPS_DEF  = 32'h8020_0003;
   localparam logic [31:0]     LFSR_SEED_DEF  = 32'h0000_0001;

   // Right-shifting Galois step: the bit shifted out selects whether the taps are applied.
   function automatic logic [LFSR_WIDTH_DEF-1:0] lfsr_step(
      input logic [LFSR_WIDTH_DEF-1:0] state,
      input logic [LFSR_WIDTH_DEF-1:0] taps
   );
      logic [LFSR_WIDTH_DEF-1:0] shifted;
      shifted = state >> 1;
      return state[0] ? (shifted ^ taps) : shifted;
   endfunction

endpackage

// File: rtl/lfsr_next.sv
// Pure combinational Galois LFSR next-state function; also used by walk-engine look-ahead.
module lfsr_next
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = LFSR_WIDTH_DEF,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_DEF)
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);

   logic [WIDTH-1:0] shifted;

   assign shifted = cur >> 1;
   assign nxt     = cur[0] ? (shifted ^ TAPS) : shifted;

endmodule

// File: rtl/lfsr32.sv
// Free-running Galois LFSR with synchronous seed load (load beats en).
// Optional zero-state guard compiled in with `define LFSR_ZERO_GUARD_EN.
module lfsr32
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = LFSR_WIDTH_DEF,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_DEF),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_SEED_DEF)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;
   logic [WIDTH-1:0] step_val;

   lfsr_next #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_next (
      .cur (state_q),
      .nxt (step_val)
   );

   always_comb begin
      state_d = state_q;
      if (load) begin
`ifdef LFSR_ZERO_GUARD_EN
         state_d = (seed == '0) ? SEED : seed;
`else
         state_d = seed;
`endif
      end
`ifdef LFSR_ZERO_GUARD_EN
      // Recover from lock-up even when the generator is idle.
      else if (state_q == '0) begin
         state_d = SEED;
      end
`endif
      else if (en) begin
         state_d = step_val;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign q = state_q;

endmodule

// File: tb/tb_lfsr32.sv
// Self-checking bench for lfsr32 against an arithmetic reference model.
module tb_lfsr32;
   import lfsr_pkg::*;

   localparam logic [31:0] TAPS = 32'h8020_0003;
   localparam logic [31:0] SEED = 32'h0000_0001;
   localparam int          RAND_STEPS = 20000;

   logic        clk;
   logic        reset;
   logic        en;
   logic        load;
   logic [31:0] seed;
   logic [31:0] q;

   int          n_tests;
   int          n_fail;
   logic [31:0] m;
   logic [31:0] prev;

   lfsr32 dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .load  (load),
      .seed  (seed),
      .q     (q)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   // Reference: halve the state; if an odd value was halved, fold the feedback polynomial back in.
   function automatic logic [31:0] model_next(input logic [31:0] s, input logic e,
                                              input logic l, input logic [31:0] d);
      logic [31:0] r;
      r = s;
      if (l) begin
`ifdef LFSR_ZERO_GUARD_EN
         r = (d == 0) ? SEED : d;
`else
         r = d;
`endif
      end
`ifdef LFSR_ZERO_GUARD_EN
      else if (s == 0) r = SEED;
`endif
      else if (e) begin
         r = s / 2;
         if ((s % 2) == 1) r = r ^ TAPS;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; drives inputs, checks after the next rising edge.
   task automatic do_cycle(input logic e, input logic l, input logic [31:0] s, input string tag);
      en   = e;
      load = l;
      seed = s;
      @(posedge clk);
      #1;
      m = model_next(m, e, l, s);
      check(tag, q, m);
      @(negedge clk);
   endtask

   initial begin
      int ones;
      int seed_hits;
      int zero_hits;
      int track_err;

      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      en      = 1'b0;
      load    = 1'b0;
      seed    = '0;

      // 1: asynchronous reset, mid-cycle at t=5
      #5 reset = 1'b0;
      #1 check("reset_async", q, SEED);
      m = SEED;
      repeat (2) begin
         @(posedge clk);
         #1 check("reset_hold", q, SEED);
      end
      @(negedge clk);
      reset = 1'b1;

      // 2: first steps, plus cross-check against the package function
      prev = q;
      do_cycle(1'b1, 1'b0, 32'h0, "seq_1");
      check("seq_1_const", q, 32'h8020_0003);
      check("seq_1_pkg", q, lfsr_step(prev, TAPS));
      prev = q;
      do_cycle(1'b1, 1'b0, 32'h0, "seq_2");
      check("seq_2_const", q, 32'hC030_0002);
      check("seq_2_pkg", q, lfsr_step(prev, TAPS));
      prev = q;
      do_cycle(1'b1, 1'b0, 32'h0, "seq_3");
      check("seq_3_const", q, 32'h6018_0001);
      check("seq_3_pkg", q, lfsr_step(prev, TAPS));

      // 3: hold and load priority
      prev = q;
      repeat (3) do_cycle(1'b0, 1'b0, $urandom, "hold");
      check("hold_const", q, prev);
      do_cycle(1'b1, 1'b1, 32'hDEAD_BEEF, "load_prio");
      check("load_prio_const", q, 32'hDEAD_BEEF);

      // 4: reset pulse between edges after 100 steps
      repeat (100) do_cycle(1'b1, 1'b0, 32'h0, "run100");
      reset = 1'b0;
      #1 check("reset_mid", q, SEED);
      m = SEED;
      #2 reset = 1'b1;
      do_cycle(1'b1, 1'b0, 32'h0, "after_reset");
      check("after_reset_const", q, 32'h8020_0003);

      // 5: zero seed
      do_cycle(1'b1, 1'b1, 32'h0, "zero_load");
`ifdef LFSR_ZERO_GUARD_EN
      check("zero_load_const", q, SEED);
`else
      check("zero_load_const", q, 32'h0);
      repeat (10) do_cycle(1'b1, 1'b0, 32'h0, "zero_lock");
      check("zero_lock_const", q, 32'h0);
`endif
      do_cycle(1'b0, 1'b1, 32'h1234_5679, "reload");

      // Random mix of en/load/seed, seeds sometimes zero
      for (int i = 0; i < 200; i++) begin
         logic [31:0] s;
         s = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         do_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), s, "rand_mix");
      end

      // 6: statistical sanity from SEED
      reset = 1'b0;
      #2 reset = 1'b1;
      m = SEED;
      ones = 0;
      seed_hits = 0;
      zero_hits = 0;
      track_err = 0;
      en   = 1'b1;
      load = 1'b0;
      for (int i = 0; i < RAND_STEPS; i++) begin
         @(posedge clk);
         #1;
         m = model_next(m, 1'b1, 1'b0, 32'h0);
         if (q !== m) track_err++;
         if (q == SEED) seed_hits++;
         if (q == 0) zero_hits++;
         if (q[0]) ones++;
      end
      @(negedge clk);
      en = 1'b0;
      check("rand_track_err", 32'(track_err), 32'h0);
      check("rand_seed_repeat", 32'(seed_hits), 32'h0);
      check("rand_zero_state", 32'(zero_hits), 32'h0);
      n_tests++;
      assert (ones >= (RAND_STEPS * 48) / 100 && ones <= (RAND_STEPS * 52) / 100) else begin
         n_fail++;
         $error("FAIL rand_bit0_balance: observed %0d ones expected %0d..%0d", ones,
                (RAND_STEPS * 48) / 100, (RAND_STEPS * 52) / 100);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
